window_sum_2x2: RTL

//   Streaming 2x2 window-sum stage placed directly downstream of the 2x decimating downsampler.

---
 rtl/window_sum_2x2.sv | 98 +++++++++
 1 files changed

// File: rtl/window_sum_2x2.sv
// rtl/window_sum_2x2.sv - streaming 2x2 window sum over a row-major raster with one-row line buffer
module window_sum_2x2 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int OUT_W  = DATA_W + 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              data_in_valid,
  input  logic [DATA_W-1:0] data_in_data,
  output logic              data_in_ready,
  output logic              data_out_valid,
  output logic [OUT_W-1:0]  data_out_data,
  input  logic              data_out_ready,
  output logic              frame_done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [DATA_W-1:0] left_q, upleft_q;
  logic [DATA_W-1:0] lb [IMG_W];
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              frame_done_q, frame_done_d;

  logic              accept, emit, last_col, last_row;
  logic [DATA_W-1:0] up;
  logic [OUT_W-1:0]  sum;

  assign data_in_ready  = ~out_valid_q | data_out_ready;
  assign accept         = data_in_valid & data_in_ready;
  assign last_col       = (x_q == XW'(IMG_W - 1));
  assign last_row       = (y_q == YW'(IMG_H - 1));
  assign emit           = (x_q != '0) && (y_q != '0);
  assign up             = lb[x_q];
  assign sum            = OUT_W'(upleft_q) + OUT_W'(up) + OUT_W'(left_q) + OUT_W'(data_in_data);
  assign data_out_valid = out_valid_q;
  assign data_out_data  = out_data_q;
  assign frame_done     = frame_done_q;

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    if (accept) begin
      if (last_col) begin
        x_d = '0;
        y_d = last_row ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      frame_done_d = last_col & last_row;
    end
    // A new sum takes priority; otherwise a consumed sum drains while data holds.
    if (accept && emit) begin
      out_valid_d = 1'b1;
      out_data_d  = sum;
    end else if (data_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_q          <= '0;
      y_q          <= '0;
      left_q       <= '0;
      upleft_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      if (accept) begin
        upleft_q <= up;
        left_q   <= data_in_data;
      end
    end
  end

  // Line buffer carries no reset; a pixel presented during RESET is discarded.
  always_ff @(posedge CLK) begin
    if (accept && !RESET) begin
      lb[x_q] <= data_in_data;
    end
  end

endmodule
